// File: rtl/ps2_ctrl_pkg.sv
// Shared types and register bit positions for the PS/2 receive controller.
package ps2_ctrl_pkg;

  // Decoder handshake sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    CLEAR    = 2'd2,
    WAIT_LOW = 2'd3
  } ps2_state_e;

  // Status register bit positions
  localparam int unsigned ST_NEMPTY  = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_IRQEN   = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  // Control register bit positions
  localparam int unsigned CTL_OVF_CLR = 2;
  localparam int unsigned CTL_IRQEN   = 3;
  localparam int unsigned CTL_FLUSH   = 7;

  // FIFO count width; holds 0..8, which is the largest legal depth
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Small circular-buffer FIFO for received scancodes.
module ps2_sync_fifo
  import ps2_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop on empty is ignored; a push on full is accepted only if a pop frees a slot
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Storage array; flush discards any same-cycle push
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// Captures PS/2 decoder bytes into a FIFO and exposes data/status/control to the CPU bus.
module ps2_rx_ctrl
  import ps2_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned IRQ_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [DATA_W-1:0] dec_data,
  output logic              dec_clr,
  input  logic              reg_sel,
  input  logic              rd_strobe,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              irq
);

  ps2_state_e        state;
  logic              ovf;
  logic              irq_en;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  logic              capture;
  logic              pop_req;
  logic              ctl_wr;
  logic              flush;
  logic              ovf_set;
  logic [DATA_W-1:0] status;
  logic              unused_wr_bits;

  // Bus-side decode; a dropped byte sets overflow only if no pop frees room and no flush wins
  always_comb begin
    capture = (state == CAPTURE);
    pop_req = rd_strobe && !reg_sel;
    ctl_wr  = wr_strobe && reg_sel;
    flush   = ctl_wr && wr_data[CTL_FLUSH];
    ovf_set = capture && fifo_full && !pop_req && !flush;
  end

  assign unused_wr_bits = ^{wr_data[6:4], wr_data[1:0]};

  // Status byte assembly
  always_comb begin
    status                         = '0;
    status[ST_NEMPTY]              = !fifo_empty;
    status[ST_FULL]                = fifo_full;
    status[ST_OVF]                 = ovf;
    status[ST_IRQEN]               = irq_en;
    status[ST_CNT_LSB +: CNT_W]    = fifo_count;
  end

  ps2_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .pop       (pop_req),
    .flush     (flush),
    .push_data (dec_data),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Decoder handshake: capture once, pulse clear, then wait for valid to drop
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dec_clr <= 1'b0;
    end else begin
      dec_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (dec_valid) state <= CAPTURE;
        end
        CAPTURE: begin
          state   <= CLEAR;
          dec_clr <= 1'b1;
        end
        CLEAR: begin
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!dec_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow (set beats clear) and interrupt enable
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ctl_wr && wr_data[CTL_OVF_CLR]) begin
        ovf <= 1'b0;
      end
      if (ctl_wr) irq_en <= wr_data[CTL_IRQEN];
    end
  end

  // Registered read mux and interrupt, both one cycle behind the state they report
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      irq     <= 1'b0;
    end else begin
      rd_data <= reg_sel ? status : (fifo_empty ? '0 : fifo_head);
      irq     <= irq_en && ((fifo_count >= CNT_W'(IRQ_THRESH)) || ovf);
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl against a queue-based transaction model.
module tb_ps2_rx_ctrl;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned IRQ_THRESH = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dec_valid = 1'b0;
  logic [7:0] dec_data = 8'h00;
  logic       dec_clr;
  logic       reg_sel = 1'b0;
  logic       rd_strobe = 1'b0;
  logic       wr_strobe = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       irq;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_en  = 1'b0;

  ps2_rx_ctrl #(
    .DEPTH      (DEPTH),
    .IRQ_THRESH (IRQ_THRESH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (dec_valid),
    .dec_data  (dec_data),
    .dec_clr   (dec_clr),
    .reg_sel   (reg_sel),
    .rd_strobe (rd_strobe),
    .wr_strobe (wr_strobe),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    int n;
    n = q.size();
    return {4'(n), 1'(m_en), 1'(m_ovf), 1'(n == DEPTH), 1'(n != 0)};
  endfunction

  function automatic logic m_irq();
    return m_en && ((q.size() >= IRQ_THRESH) || m_ovf);
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  // Present one byte as the decoder would; drop valid once cleared
  task automatic send_byte(input logic [7:0] b);
    int n;
    dec_data  = b;
    dec_valid = 1'b1;
    n = 0;
    while (dec_clr !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("dec_clr_latency", 8'(n), 8'd2);
    m_push(b);
    dec_valid = 1'b0;
    tick();
    chk("dec_clr_single", 8'(dec_clr), 8'd0);
    tick();
  endtask

  task automatic read_data();
    logic [7:0] exp;
    reg_sel = 1'b0;
    tick();
    exp = (q.size() != 0) ? q[0] : 8'h00;
    chk("data", rd_data, exp);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic read_status();
    reg_sel = 1'b1;
    tick();
    chk("status", rd_data, m_status());
  endtask

  task automatic write_ctl(input logic [7:0] v);
    reg_sel   = 1'b1;
    wr_data   = v;
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    m_en = v[3];
    if (v[2]) m_ovf = 1'b0;
    if (v[7]) q.delete();
  endtask

  task automatic chk_irq(input string tag);
    tick();
    chk(tag, 8'(irq), 8'(m_irq()));
  endtask

  initial begin
    logic [7:0] b;
    int cnt;
    int op;

    // Reset values
    tick();
    tick();
    reset = 1'b0;
    chk("rst_dec_clr", 8'(dec_clr), 8'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_irq", 8'(irq), 8'd0);
    read_status();

    // Single capture: status 0x11, then read back and empty again
    send_byte(8'h1C);
    read_status();
    chk("t1_status_const", rd_data, 8'h11);
    read_data();
    read_status();
    chk("t1_status_empty", rd_data, 8'h00);

    // Fill to full, overflow, drain in order
    write_ctl(8'h08);
    chk_irq("t2_irq_empty");
    send_byte(8'h01);
    chk_irq("t2_irq_first");
    chk("t2_irq_high", 8'(irq), 8'd1);
    for (int i = 2; i <= 9; i++) send_byte(8'(i));
    read_status();
    chk("t2_status_full", rd_data, 8'h8F);
    for (int i = 0; i < 8; i++) read_data();
    read_status();
    chk_irq("t2_irq_ovf_only");

    // Overflow clear: irq drops one cycle after the write
    write_ctl(8'h0C);
    chk("t4_irq_lag", 8'(irq), 8'd1);
    tick();
    chk("t4_irq_fall", 8'(irq), 8'd0);
    read_status();
    chk("t4_status", rd_data, 8'h08);

    // Coincident push and pop with 3 held, crossing the pointer wrap
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    for (int i = 0; i < 7; i++) begin
      b = 8'($urandom);
      dec_data  = b;
      dec_valid = 1'b1;
      reg_sel   = 1'b0;
      tick();
      rd_strobe = 1'b1;
      tick();
      rd_strobe = 1'b0;
      chk("t3_pp_head", rd_data, q[0]);
      chk("t3_pp_clr", 8'(dec_clr), 8'd1);
      void'(q.pop_front());
      q.push_back(b);
      dec_valid = 1'b0;
      tick();
      tick();
      read_status();
    end
    for (int i = 0; i < 3; i++) read_data();
    read_status();

    // Flush coincident with a capture push
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    read_status();
    dec_data  = 8'($urandom);
    dec_valid = 1'b1;
    tick();
    reg_sel   = 1'b1;
    wr_data   = 8'h80;
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    q.delete();
    m_en = 1'b0;
    chk("t5_clr", 8'(dec_clr), 8'd1);
    dec_valid = 1'b0;
    tick();
    tick();
    read_status();
    chk("t5_status", rd_data, 8'h00);
    send_byte(8'h2A);
    read_data();
    read_data();
    read_status();

    // Reset while waiting for valid to drop; byte recaptured exactly once
    write_ctl(8'h08);
    dec_data  = 8'h5B;
    dec_valid = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_en  = 1'b0;
    chk("t6_dec_clr", 8'(dec_clr), 8'd0);
    chk("t6_rd_data", rd_data, 8'h00);
    chk("t6_irq", 8'(irq), 8'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dec_clr === 1'b1) cnt++;
    end
    chk("t6_clr_count", 8'(cnt), 8'd1);
    q.push_back(8'h5B);
    dec_valid = 1'b0;
    tick();
    tick();
    read_status();
    read_data();
    read_status();

    // Random transaction mix against the model
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0, 1, 2: send_byte(8'($urandom));
        3, 4:    read_data();
        5:       read_status();
        default: begin
          b = 8'($urandom);
          if ($urandom_range(0, 3) != 0) b[7] = 1'b0;
          write_ctl(b);
        end
      endcase
      chk_irq("rnd_irq");
    end
    read_status();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
